serial_addsub: RTL and testbench

Parametrised digit-serial adder/subtractor, the successor to the single-bit `serial_adder`. It accepts two W-bit operands in parallel and processes them LSB-first, D bits per clock, through one shared D-bit adder slice. It returns a parallel W-bit result with carry-out and signed overflow, using a start/busy/done handshake. It sits between a register-file style producer and any consumer that can tolerate W/D cycles of latency in exchange for a narrow adder.

---
 rtl/serial_addsub.sv | 133 +++++++++++++
 tb/tb_serial_addsub.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, LSB-first, D bits per clock.
// Parallel W-bit operands in, parallel W-bit result with carry-out and signed
// overflow out, using a start/busy/done handshake.
// Build option: define SERIAL_ADDSUB_SUB_EN to enable subtraction through the
// sub port. Without it the sub port is ignored and the block only adds.
module serial_addsub #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 1
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned N  = W / D;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject parameter combinations that cannot be split into whole digits
  if (W < 2 || D < 1 || D > W || (W % D) != 0) begin : g_bad_params
    $error("serial_addsub: illegal W=%0d / D=%0d", W, D);
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          sub_eff;
  logic [D:0]    sum_c;

`ifdef SERIAL_ADDSUB_SUB_EN
  assign sub_eff = sub;
`else
  // Adder-only build: the port stays for pin compatibility but has no effect
  assign sub_eff = sub & 1'b0;
`endif

  // Shared D-bit adder slice working on the low digit of each operand
  assign sum_c = (D+1)'(a_q[D-1:0]) + (D+1)'(b_q[D-1:0]) + (D+1)'(carry_q);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub_eff ? ~b : b;
          carry_d = sub_eff;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        res_d   = W'({sum_c[D-1:0], res_q} >> D);
        a_d     = a_q >> D;
        b_d     = b_q >> D;
        carry_d = sum_c[D];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          cout_d  = sum_c[D];
          // carry into the MSB recovered as a ^ b ^ sum at the top bit
          ovf_d   = a_q[D-1] ^ b_q[D-1] ^ sum_c[D-1] ^ sum_c[D];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors for serial_addsub at W=8 with D=1 and D=4.
module tb_serial_addsub;

  logic       clk;
  logic       clear_n;
  logic       start1, sub1, start4, sub4;
  logic [7:0] a1, b1, a4, b4;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] res1, res4;
  logic       sel;
  logic       busy_s, done_s, cout_s, ovf_s;
  logic [7:0] res_s;

  int n_vec = 0;
  int n_err = 0;

  serial_addsub #(.W(8), .D(1)) u_d1 (
    .clk(clk), .clear_n(clear_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1)
  );

  serial_addsub #(.W(8), .D(4)) u_d4 (
    .clk(clk), .clear_n(clear_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4)
  );

  assign busy_s = sel ? busy4 : busy1;
  assign done_s = sel ? done4 : done1;
  assign res_s  = sel ? res4  : res1;
  assign cout_s = sel ? cout4 : cout1;
  assign ovf_s  = sel ? ovf4  : ovf1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b, input logic s);
    if (sel) begin start4 = st; a4 = a; b4 = b; sub4 = s; end
    else     begin start1 = st; a1 = a; b1 = b; sub1 = s; end
  endtask

  // One complete operation on the selected instance, checking latency and outputs
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [7:0] er, input logic ec,
                       input logic eo, input int elat);
    int lat;
    int bcnt;
    @(negedge clk);
    drive(1'b1, a, b, s);
    @(posedge clk); #1;
    check({tag, "_busy_e0"}, 32'(busy_s), 32'd1);
    lat  = 0;
    bcnt = 1;
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    while (!done_s && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy_s) bcnt++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(elat));
    check({tag, "_result"}, 32'(res_s), 32'(er));
    check({tag, "_cout"}, 32'(cout_s), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf_s), 32'(eo));
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done_s), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [7:0] seen;
    sel = 1'b0;
    clear_n = 1'b0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    #2;
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_res1", 32'(res1), 32'd0);
    check("rst_cout1", 32'(cout1), 32'd0);
    check("rst_ovf1", 32'(ovf1), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;

    // D=1 additions
    do_op("add7_3", 8'd7, 8'd3, 1'b0, 8'd10, 1'b0, 1'b0, 8);
    do_op("add200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 8);
    do_op("add100_50", 8'd100, 8'd50, 1'b0, 8'd150, 1'b0, 1'b1, 8);

    // Subtraction requests; adder-only build ignores sub
`ifdef SERIAL_ADDSUB_SUB_EN
    do_op("sub5_7", 8'd5, 8'd7, 1'b1, 8'd254, 1'b0, 1'b0, 8);
    do_op("sub128_1", 8'd128, 8'd1, 1'b1, 8'd127, 1'b1, 1'b1, 8);
`else
    do_op("sub5_7", 8'd5, 8'd7, 1'b1, 8'd12, 1'b0, 1'b0, 8);
    do_op("sub128_1", 8'd128, 8'd1, 1'b1, 8'd129, 1'b0, 1'b0, 8);
`endif

    // D=4
    sel = 1'b1;
    do_op("d4_add7_3", 8'd7, 8'd3, 1'b0, 8'd10, 1'b0, 1'b0, 2);

    // D=4 back-to-back: start held through the done cycle
    @(negedge clk);
    drive(1'b1, 8'd7, 8'd3, 1'b0);
    @(posedge clk); #1;                                   // E0
    @(negedge clk);
    drive(1'b1, 8'd255, 8'd1, 1'b0);
    @(posedge clk); #1;                                   // E1
    check("b2b_e1_busy", 32'(busy4), 32'd1);
    check("b2b_e1_done", 32'(done4), 32'd0);
    @(posedge clk); #1;                                   // E2
    check("b2b_first_done", 32'(done4), 32'd1);
    check("b2b_first_res", 32'(res4), 32'd10);
    @(posedge clk); #1;                                   // E3: second accepted
    check("b2b_second_busy", 32'(busy4), 32'd1);
    check("b2b_second_nodone", 32'(done4), 32'd0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    check("b2b_e4_done", 32'(done4), 32'd0);
    @(posedge clk); #1;
    check("b2b_second_done", 32'(done4), 32'd1);
    check("b2b_second_res", 32'(res4), 32'd0);
    check("b2b_second_cout", 32'(cout4), 32'd1);
    check("b2b_second_ovf", 32'(ovf4), 32'd0);

    // D=1: start while busy is ignored
    sel = 1'b0;
    @(negedge clk);
    drive(1'b1, 8'd7, 8'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b1, 8'd9, 8'd9, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    pulses = 0;
    seen   = 8'hxx;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done1) begin pulses++; seen = res1; end
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_result", 32'(seen), 32'd10);

    // D=1: asynchronous clear four cycles into an operation
    @(negedge clk);
    drive(1'b1, 8'd100, 8'd50, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    clear_n = 1'b0;
    #1;
    check("clr_busy", 32'(busy1), 32'd0);
    check("clr_done", 32'(done1), 32'd0);
    check("clr_res", 32'(res1), 32'd0);
    check("clr_cout", 32'(cout1), 32'd0);
    check("clr_ovf", 32'(ovf1), 32'd0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) pulses++;
    end
    check("clr_no_done", 32'(pulses), 32'd0);
    do_op("after_clr", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
